// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data RAM arbiter.
// Requests are carried as one struct so the winner mux is a single array select.
package data_mem_pkg;

  localparam int BE_WIDTH       = 4;
  localparam int NUM_PORTS      = 2;
  localparam int MAX_ADDR_WIDTH = 32;
  localparam int WORD_WIDTH     = 32;

  // Address is zero-extended to MAX_ADDR_WIDTH so the range check needs no extra width logic.
  typedef struct packed {
    logic [MAX_ADDR_WIDTH-1:0] addr;
    logic                      we;
    logic [BE_WIDTH-1:0]       be;
    logic [WORD_WIDTH-1:0]     wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way arbiter.
// Round-robin on the last granted port, or fixed priority to port 0 when RR_EN is clear.
module rr_arbiter_2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q;

  // On contention the port that was not granted last wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      if (RR_EN && !last_q) begin
        gnt = 2'b10;
      end else begin
        gnt = 2'b01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (|gnt) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data RAM between the LSU (port 0) and the debug/loader port (port 1).
// Out-of-range accesses are granted but never reach the RAM; they return an error response.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 256,
  parameter int RR_EN      = 1
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  p0_req_i,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  input  logic                  p0_we_i,
  input  logic [BE_WIDTH-1:0]   p0_be_i,
  input  logic [DATA_WIDTH-1:0] p0_wdata_i,
  output logic                  p0_gnt_o,
  output logic                  p0_rvalid_o,
  output logic [DATA_WIDTH-1:0] p0_rdata_o,
  output logic                  p0_err_o,
  input  logic                  p1_req_i,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic                  p1_we_i,
  input  logic [BE_WIDTH-1:0]   p1_be_i,
  input  logic [DATA_WIDTH-1:0] p1_wdata_i,
  output logic                  p1_gnt_o,
  output logic                  p1_rvalid_o,
  output logic [DATA_WIDTH-1:0] p1_rdata_o,
  output logic                  p1_err_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [BE_WIDTH-1:0]   ram_be_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  mem_req_t             port_req [NUM_PORTS];
  logic [NUM_PORTS-1:0] req_vec;
  logic [NUM_PORTS-1:0] gnt_vec;
  logic                 sel;
  mem_req_t             win;
  logic                 accept;
  logic                 in_range;

  logic resp_valid_q;
  logic resp_port_q;
  logic resp_err_q;
  logic resp_rd_q;

  logic [NUM_PORTS-1:0]  rvalid_vec;
  logic [NUM_PORTS-1:0]  err_vec;
  logic [DATA_WIDTH-1:0] rdata_vec [NUM_PORTS];

  assign port_req[0] = '{addr:  MAX_ADDR_WIDTH'(p0_addr_i), we: p0_we_i, be: p0_be_i,
                         wdata: WORD_WIDTH'(p0_wdata_i)};
  assign port_req[1] = '{addr:  MAX_ADDR_WIDTH'(p1_addr_i), we: p1_we_i, be: p1_be_i,
                         wdata: WORD_WIDTH'(p1_wdata_i)};

  // Masking requests during reset keeps grants and RAM strobes low without touching the arbiter.
  assign req_vec = {p1_req_i, p0_req_i} & {NUM_PORTS{~rst_i}};

  rr_arbiter_2 #(
    .RR_EN (RR_EN != 0)
  ) u_arb (
    .clk   (clk),
    .rst_i (rst_i),
    .req   (req_vec),
    .gnt   (gnt_vec)
  );

  // With no grant sel is 0, so address and data idle on port 0's values.
  assign sel      = gnt_vec[1];
  assign win      = port_req[sel];
  assign accept   = |gnt_vec;
  assign in_range = win.addr < MAX_ADDR_WIDTH'(NUM_WORDS);

  assign p0_gnt_o    = gnt_vec[0];
  assign p1_gnt_o    = gnt_vec[1];
  assign ram_en_o    = accept & in_range;
  assign ram_addr_o  = win.addr[ADDR_WIDTH-1:0];
  assign ram_we_o    = ram_en_o & win.we;
  assign ram_be_o    = ram_en_o ? win.be : '0;
  assign ram_wdata_o = win.wdata[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst_i) begin
      resp_valid_q <= 1'b0;
      resp_port_q  <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rd_q    <= 1'b0;
    end else begin
      resp_valid_q <= accept;
      resp_port_q  <= sel;
      resp_err_q   <= accept & ~in_range;
      resp_rd_q    <= accept & in_range & ~win.we;
    end
  end

  // Only in-range reads forward RAM data; writes and errors return zero.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_resp
    assign rvalid_vec[gi] = resp_valid_q && (resp_port_q == 1'(gi));
    assign err_vec[gi]    = rvalid_vec[gi] & resp_err_q;
    assign rdata_vec[gi]  = (rvalid_vec[gi] && resp_rd_q) ? ram_rdata_i : '0;
  end

  assign p0_rvalid_o = rvalid_vec[0];
  assign p0_err_o    = err_vec[0];
  assign p0_rdata_o  = rdata_vec[0];
  assign p1_rvalid_o = rvalid_vec[1];
  assign p1_err_o    = err_vec[1];
  assign p1_rdata_o  = rdata_vec[1];

endmodule
